ctrl_pipe: RTL
==============

Name: ctrl_pipe

Overview:
- Second-generation control unit for the 16-bit five-stage core.
- Decodes the D-stage instruction into a control bundle and carries it through the EX, MEM and WB control registers.
- Generates RAW-hazard stalls, branch flushes, memory-stall freezes and a halt drain sequence.
- Replaces the per-stage ad-hoc control latching; datapath stage registers consume its per-stage outputs.

Parameters:
- FWD_EN, 1: 1 = EX/MEM forwarding exists, so only load-use stalls; 0 = stall on any RAW against an in-flight writer.
- RF_BYPASS, 1: 1 = a register-file write is readable in the same cycle, so the WB writer is never a hazard; 0 = WB writer is a hazard.
- LINK_REG, 7: destination register for JAL/JALR.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- instr_valid  in  1  D-stage instruction valid
- instr_d  in  16  D-stage instruction; op=[15:11], rs=[10:8], rt=[7:5], rdR=[4:2], func=[1:0]
- mem_stall  in  1  data memory busy; freeze all stages
- flush_ex  in  1  branch/jump resolved taken in EX; kill the D instruction
- stall_fd  out  1  hold PC and the IF/D register
- ex_alu_op  out  3  EX ALU operation
- ex_alu_src  out  1  EX operand B is the immediate
- ex_inv_b  out  1  EX invert operand B
- mem_we  out  1  MEM write enable
- mem_re  out  1  MEM read enable
- wb_we  out  1  WB register write enable
- wb_waddr  out  3  WB destination register
- halted  out  1  sticky halt, set when HALT retires

Behaviour:
- Reset (synchronous, active-high): all stage valids 0, every output 0, FSM in RUN.
- Decode (combinational, D stage):
  - Dest [7:5]: ADDI/SUBI/XORI/ANDNI, ROLI group, LD.
  - Dest [10:8]: STU, LBI, SLBI.
  - Dest [4:2]: BTR, 11011, 11010, 111xx.
  - Dest LINK_REG: op 00110/00111.
  - No write: HALT, NOP, ST, branches, J, JR.
  - Reads rs: all except HALT, NOP, LBI, J, JAL.
  - Reads rt: ST, STU, 11011, 11010, 111xx.
  - ALU op: add (100) unless the op defines another; ex_inv_b=1 for SUBI and for 11011 with func=11.
  - mem_we: ST, STU. mem_re: LD.
- Control advance:
  - Every un-stalled cycle: D→EX, EX→MEM, MEM→WB, each with its valid bit.
  - Outputs of a stage are gated to 0 when that stage is invalid.
- Hazard (D instr valid, reads reg R):
  - FWD_EN=1: stall iff EX holds a valid LD with dest R.
  - FWD_EN=0: stall iff a valid writer in EX or MEM has dest R, or (RF_BYPASS=0) in WB.
  - On stall: stall_fd=1, a bubble (valid 0) enters EX, MEM/WB advance.
- Priority: rst > mem_stall > flush_ex > hazard.
  - mem_stall: all control registers hold; stall_fd=1; no bubble is created.
  - flush_ex with mem_stall=0: the D instruction becomes a bubble in EX; stall_fd=0; the EX instruction advances normally.
  - flush_ex arriving during mem_stall is held by its source until release.
- FSM:
  - RUN: on a valid, un-flushed HALT accepted into EX → DRAIN. The HALT itself advances.
  - DRAIN: stall_fd=1, bubbles enter EX. When HALT is valid in WB → HALTED.
  - HALTED: halted=1, stall_fd=1, all valids 0. Exit only via rst.
  - A flushed HALT is ignored.
- Reset mid-operation: all in-flight control is discarded the next edge; no write enables are asserted in that cycle's register outputs.

Test Plan:
1. FWD_EN=1: LD r2 then ADD r3,r2,r1 back-to-back → stall_fd=1 for exactly 1 cycle, one bubble in EX, ADD reaches WB with wb_we=1, wb_waddr=3.
2. FWD_EN=0, RF_BYPASS=0: ADDI r4 followed by SUB reading r4 → 3 stall cycles; with RF_BYPASS=1 → 2 stall cycles.
3. flush_ex=1 while the D instruction is ST → mem_we never asserts for that ST; stall_fd=0 that cycle.
4. mem_stall=1 for 4 cycles with LD in MEM → all outputs constant for those cycles, mem_re stays 1, then normal advance.
5. HALT (instr 0x0000) → stall_fd rises the cycle after acceptance, halted=1 three cycles later, stays 1 until rst; rst clears halted and all enables the next edge.
6. JAL (op 00110) → wb_we=1, wb_waddr=LINK_REG (7) at WB; override LINK_REG=5 → wb_waddr=5.

Source files
------------

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: decode-stage inputs and per-stage control outputs of the pipeline control unit
interface ctrl_pipe_if;
  logic        instr_valid;
  logic [15:0] instr_d;
  logic        mem_stall;
  logic        flush_ex;
  logic        stall_fd;
  logic [2:0]  ex_alu_op;
  logic        ex_alu_src;
  logic        ex_inv_b;
  logic        mem_we;
  logic        mem_re;
  logic        wb_we;
  logic [2:0]  wb_waddr;
  logic        halted;
  modport master (
    output instr_valid, instr_d, mem_stall, flush_ex,
    input  stall_fd, ex_alu_op, ex_alu_src, ex_inv_b, mem_we, mem_re, wb_we, wb_waddr, halted
  );
  modport slave (
    input  instr_valid, instr_d, mem_stall, flush_ex,
    output stall_fd, ex_alu_op, ex_alu_src, ex_inv_b, mem_we, mem_re, wb_we, wb_waddr, halted
  );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: decodes the D-stage instruction and carries EX/MEM/WB control with hazard, flush, freeze and halt drain
module ctrl_pipe #(
  parameter bit         FWD_EN    = 1'b1,
  parameter bit         RF_BYPASS = 1'b1,
  parameter logic [2:0] LINK_REG  = 3'd7
) (
  input logic        clk,
  input logic        rst,
  ctrl_pipe_if.slave bus
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  typedef struct packed {
    logic       v;
    logic       halt;
    logic       ld;
    logic       we;
    logic [2:0] dst;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       inv_b;
    logic       mwe;
    logic       mre;
  } ex_t;
  typedef struct packed {
    logic       v;
    logic       halt;
    logic       we;
    logic [2:0] dst;
    logic       mwe;
    logic       mre;
  } mem_t;
  typedef struct packed {
    logic       v;
    logic       halt;
    logic       we;
    logic [2:0] dst;
  } wb_t;
  state_t      state_q, state_d;
  ex_t         ex_q, ex_d, dec;
  mem_t        mem_q, mem_d;
  wb_t         wb_q, wb_d;
  logic [4:0]  op;
  logic [2:0]  rs, rt, rd;
  logic [1:0]  func;
  logic        rd_rs, rd_rt, hazard, accept;
  assign {op, rs, rt, rd, func} = bus.instr_d;
  function automatic logic hit(input logic v, input logic we, input logic [2:0] d, input logic [2:0] r);
    return v && we && d == r;
  endfunction
  // with forwarding only a load still in EX cannot supply its result in time
  function automatic logic raw(input logic [2:0] r, input ex_t e, input mem_t m, input wb_t w);
    return FWD_EN ? hit(e.v, e.we && e.ld, e.dst, r)
                  : hit(e.v, e.we, e.dst, r) || hit(m.v, m.we, m.dst, r) || (!RF_BYPASS && hit(w.v, w.we, w.dst, r));
  endfunction
  always_comb begin
    dec = '0;
    dec.v = 1'b1;
    dec.halt = op == 5'b00000;
    dec.ld = op == 5'b10001;
    dec.mwe = op == 5'b10000 || op == 5'b10011;
    dec.mre = op == 5'b10001;
    dec.alu_src = op[4:2] inside {3'b010, 3'b100, 3'b101} || op inside {5'b11000, 5'b00101, 5'b00111};
    dec.inv_b = op == 5'b01001 || (op == 5'b11011 && func == 2'b11);
    dec.alu_op = op == 5'b01010 ? 3'b110 :
                 op == 5'b01011 ? 3'b111 :
                 op[4:2] == 3'b101 ? {1'b0, op[1:0]} :
                 op == 5'b11010 ? {1'b0, func} :
                 (op == 5'b11011 && func[1]) ? {2'b11, func[0]} : 3'b100;
    casez (op)
      5'b010??, 5'b101??, 5'b10001: {dec.we, dec.dst} = {1'b1, rt};
      5'b10011, 5'b11000, 5'b10010: {dec.we, dec.dst} = {1'b1, rs};
      5'b11001, 5'b1101?, 5'b111??: {dec.we, dec.dst} = {1'b1, rd};
      5'b0011?:                     {dec.we, dec.dst} = {1'b1, LINK_REG};
      default: ;
    endcase
    rd_rs = !(op inside {5'b00000, 5'b00001, 5'b11000, 5'b00100, 5'b00110});
    rd_rt = op inside {5'b10000, 5'b10011, 5'b11010, 5'b11011} || op[4:2] == 3'b111;
    hazard = bus.instr_valid && ((rd_rs && raw(rs, ex_q, mem_q, wb_q)) || (rd_rt && raw(rt, ex_q, mem_q, wb_q)));
    accept = bus.instr_valid && state_q == RUN && !bus.flush_ex && !hazard && !bus.mem_stall;
    ex_d = bus.mem_stall ? ex_q : accept ? dec : '0;
    mem_d = bus.mem_stall ? mem_q : {ex_q.v, ex_q.halt, ex_q.we, ex_q.dst, ex_q.mwe, ex_q.mre};
    wb_d = bus.mem_stall ? wb_q : {mem_q.v, mem_q.halt, mem_q.we, mem_q.dst};
    state_d = bus.mem_stall ? state_q :
              (state_q == RUN && accept && dec.halt) ? DRAIN :
              (state_q == DRAIN && wb_q.v && wb_q.halt) ? HALTED : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ex_q <= '0;
      mem_q <= '0;
      wb_q <= '0;
    end else begin
      state_q <= state_d;
      ex_q <= ex_d;
      mem_q <= mem_d;
      wb_q <= wb_d;
    end
  end
  // invalid stages always hold an all-zero bundle, so fields need no extra gating
  assign bus.stall_fd = bus.mem_stall || state_q != RUN || (!bus.flush_ex && hazard);
  assign bus.ex_alu_op = ex_q.alu_op;
  assign bus.ex_alu_src = ex_q.alu_src;
  assign bus.ex_inv_b = ex_q.inv_b;
  assign bus.mem_we = mem_q.mwe;
  assign bus.mem_re = mem_q.mre;
  assign bus.wb_we = wb_q.we;
  assign bus.wb_waddr = wb_q.dst;
  assign bus.halted = state_q == HALTED;
endmodule
